uart_receiver: RTL and testbench

UART receive stage that sits downstream of the UART transmitter and consumes its serial `Tx` line (wired to `Rx` here). It synchronises the line, detects the start bit, samples 8 data bits LSB-first at mid-bit, checks the stop bit, and holds the received byte in a single-entry buffer. A valid/acknowledge handshake drains the buffer. Framing errors and overruns are flagged to the consumer.

---
 rtl/uart_receiver.sv | 112 +++++++++++
 tb/tb_uart_receiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with two-flop synchroniser, single-entry
// read buffer, one-cycle framing-error pulse and sticky overrun flag.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx,
    input  logic       Read_ack,
    output logic [7:0] Data_Out,
    output logic       Data_valid,
    output logic       Frame_error,
    output logic       Overrun
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done_q, done_d;
    logic            stop_q, stop_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            fe_q, fe_d;
    logic            ovr_q, ovr_d;
    logic            rx_s, good, accept;

    assign rx_s        = sync_q[1];
    assign Data_Out    = data_q;
    assign Data_valid  = valid_q;
    assign Frame_error = fe_q;
    assign Overrun     = ovr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        stop_d  = stop_q;
        case (state_q)
            IDLE: if (!rx_s) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (cnt_q == HALF_LAST) begin
                state_d = rx_s ? IDLE : DATA;
                cnt_d   = '0;
                idx_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            DATA: if (cnt_q == BIT_LAST) begin
                shift_d[idx_q] = rx_s;
                cnt_d          = '0;
                state_d        = (idx_q == 3'd7) ? STOP : DATA;
                idx_d          = (idx_q == 3'd7) ? idx_q : idx_q + 3'd1;
            end else cnt_d = cnt_q + 1'b1;
            STOP: if (cnt_q == BIT_LAST) begin
                done_d  = 1'b1;
                stop_d  = rx_s;
                cnt_d   = '0;
                state_d = rx_s ? IDLE : WAIT_HIGH;
            end else cnt_d = cnt_q + 1'b1;
            WAIT_HIGH: state_d = rx_s ? IDLE : WAIT_HIGH;
            default: state_d = IDLE;
        endcase
    end

    // The buffer is updated one edge after the stop sample, from the registered verdict.
    always_comb begin
        good    = done_q & stop_q;
        accept  = Read_ack & valid_q;
        data_d  = (good && (!valid_q || Read_ack)) ? shift_q : data_q;
        valid_d = good | (valid_q & ~Read_ack);
        ovr_d   = accept ? 1'b0 : (ovr_q | (good & valid_q));
        fe_d    = done_q & ~stop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            stop_q  <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], Rx};
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against a
// byte-level model of the receive buffer, overrun and framing-error rules.
module tb_uart_receiver;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx = 1'b1;
    logic       Read_ack = 1'b0;
    logic [7:0] Data_Out;
    logic       Data_valid, Frame_error, Overrun;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int fe_base;

    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_data = 8'h00;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .Rx(Rx), .Read_ack(Read_ack),
        .Data_Out(Data_Out), .Data_valid(Data_valid),
        .Frame_error(Frame_error), .Overrun(Overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) fe_cnt <= rst ? 0 : fe_cnt + int'(Frame_error);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag, input logic fe_exp);
        chk({tag, "_valid"}, 32'(Data_valid), 32'(m_valid));
        chk({tag, "_data"}, 32'(Data_Out), 32'(m_data));
        chk({tag, "_ovr"}, 32'(Overrun), 32'(m_ovr));
        chk({tag, "_fe"}, 32'(Frame_error), 32'(fe_exp));
    endtask

    // One buffer event: an optional completed good byte and an optional ack.
    task automatic m_step(input logic good, input logic [7:0] b, input logic ack);
        logic acc;
        acc = ack && m_valid;
        if (good) begin
            if (!m_valid || ack) m_data = b;
            else m_ovr = 1'b1;
            m_valid = 1'b1;
        end else if (acc) m_valid = 1'b0;
        if (acc) m_ovr = 1'b0;
    endtask

    // Drives start, 8 data bits LSB-first, stop; n_ticks truncates the frame.
    task automatic send(input logic [7:0] b, input logic stop, input int n_ticks = 10 * CPB);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int t = 0; t < n_ticks; t++) begin
            Rx = fr[t / CPB];
            tick();
        end
    endtask

    task automatic ack_pulse();
        Read_ack = 1'b1;
        tick();
        Read_ack = 1'b0;
        m_step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic finish_frame(input logic [7:0] b, input string tag);
        tick();
        chk({tag, "_lat40_valid"}, 32'(Data_valid), 32'(m_valid));
        tick();
        m_step(1'b1, b, 1'b0);
        chk_model(tag, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        int mode;
        repeat (3) tick();
        rst = 1'b0;
        chk_model("reset", 1'b0);

        send(8'h24, 1'b1);
        finish_frame(8'h24, "single");
        ack_pulse();
        chk_model("single_ack", 1'b0);

        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        tick();
        tick();
        m_step(1'b1, 8'hA5, 1'b0);
        m_step(1'b1, 8'h3C, 1'b0);
        chk_model("b2b", 1'b0);
        ack_pulse();
        chk_model("b2b_ack", 1'b0);

        send(8'hA5, 1'b1);
        finish_frame(8'hA5, "sim_first");
        send(8'h3C, 1'b1);
        tick();
        Read_ack = 1'b1;
        tick();
        Read_ack = 1'b0;
        m_step(1'b1, 8'h3C, 1'b1);
        chk_model("sim_ack", 1'b0);
        ack_pulse();

        fe_base = fe_cnt;
        Rx = 1'b0;
        tick();
        Rx = 1'b1;
        repeat (50) tick();
        chk_model("glitch", 1'b0);
        chk("glitch_fe_cnt", 32'(fe_cnt), 32'(fe_base));

        send(8'h55, 1'b0);
        tick();
        chk("fe_early", 32'(Frame_error), 32'h0);
        tick();
        chk_model("fe_pulse", 1'b1);
        fe_base = fe_cnt + 1;
        repeat (17) tick();
        chk_model("fe_hold", 1'b0);
        chk("fe_single_pulse", 32'(fe_cnt), 32'(fe_base));
        Rx = 1'b1;
        repeat (CPB) tick();
        send(8'h81, 1'b1);
        finish_frame(8'h81, "after_fe");
        ack_pulse();

        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            if (mode == 1) ack_pulse();
            repeat ($urandom_range(0, 5)) tick();
            send(rb, 1'b1);
            tick();
            Read_ack = (mode == 2);
            tick();
            Read_ack = 1'b0;
            m_step(1'b1, rb, mode == 2);
            chk_model($sformatf("rand%0d", n), 1'b0);
        end

        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h99, 1'b1, 22);
        m_step(1'b1, 8'h11, 1'b0);
        m_step(1'b1, 8'h22, 1'b0);
        chk("pre_rst_ovr", 32'(Overrun), 32'(m_ovr));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        Rx = 1'b1;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_data = 8'h00;
        chk_model("mid_rst", 1'b0);
        repeat (2 * CPB) tick();
        send(8'hF0, 1'b1);
        finish_frame(8'hF0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
